// File: rtl/kulisch_to_fp16.sv
// kulisch_to_fp16
//   Converts a wide carry-save Kulisch accumulator (two's complement, value =
//   raw * 2^-FWIDTH) into one IEEE-754 FP16 result with round-to-nearest-even,
//   overflow and subnormal handling. One transaction in flight at a time.
//
//   Pipeline of states: IDLE -> RESOLVE -> NORM -> ROUND -> HOLD.
//
//   Ports:
//     clk, rst_n        clock (rising edge), asynchronous active-low reset
//     i_valid, o_ready  operand handshake (o_ready high only in IDLE)
//     i_sum_acc         accumulator sum vector   [AWIDTH]
//     i_carry_acc       accumulator carry vector [AWIDTH]
//     i_nan             upstream NaN/invalid flag for this accumulation
//     o_valid, i_ready  result handshake (result held stable in HOLD)
//     o_result          FP16 result             [DWIDTH]
//     o_overflow        result overflowed (Inf or saturated)
//     o_underflow       subnormal/zero result from nonzero value, inexact
//     o_inexact         rounding discarded nonzero bits
//
//   Build option: define KULISCH_SAT_EN to saturate overflows to +/-65504
//   instead of returning +/-Inf.

module kulisch_to_fp16 #(
    parameter int AWIDTH = 92,
    parameter int FWIDTH = 48,
    parameter int DWIDTH = 16,
    parameter int EWIDTH = 5,
    parameter int MWIDTH = 10
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              i_valid,
    output logic              o_ready,
    input  logic [AWIDTH-1:0] i_sum_acc,
    input  logic [AWIDTH-1:0] i_carry_acc,
    input  logic              i_nan,
    output logic              o_valid,
    input  logic              i_ready,
    output logic [DWIDTH-1:0] o_result,
    output logic              o_overflow,
    output logic              o_underflow,
    output logic              o_inexact
);

    localparam int PW   = $clog2(AWIDTH);          // leading-one index width
    localparam int XW   = PW + 2;                  // signed unbiased exponent width
    localparam int BIAS = (1 << (EWIDTH - 1)) - 1;
    // Bit of M that carries the FP16 subnormal LSB (2^-(BIAS-1+MWIDTH)).
    localparam int SB   = FWIDTH - (BIAS - 1) - MWIDTH;

    localparam logic signed [XW-1:0] EMAX    = XW'(BIAS);
    localparam logic signed [XW-1:0] EMIN    = XW'(1 - BIAS);
    localparam logic        [XW-1:0] EXP_TOP = XW'((1 << EWIDTH) - 1);

    typedef enum logic [2:0] {
        IDLE,
        RESOLVE,
        NORM,
        ROUND,
        HOLD
    } state_t;

    state_t state_q, state_d;

    logic [AWIDTH-1:0]     sum_q, carry_q;
    logic                  nan_q;
    logic                  sign_q;
    logic [AWIDTH-1:0]     mag_q;
    logic [AWIDTH-1:0]     norm_q;
    logic signed [XW-1:0]  exp_q;
    logic [DWIDTH-1:0]     result_q, result_d;
    logic                  ovf_q, ovf_d;
    logic                  unf_q, unf_d;
    logic                  inx_q, inx_d;

    // ------------------------------------------------------------------
    // FSM
    // ------------------------------------------------------------------
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state_q <= IDLE;
        else        state_q <= state_d;
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    if (i_valid) state_d = RESOLVE;
            RESOLVE: state_d = NORM;
            NORM:    state_d = ROUND;
            ROUND:   state_d = HOLD;
            HOLD:    if (i_ready) state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    assign o_ready = (state_q == IDLE);
    assign o_valid = (state_q == HOLD);

    // ------------------------------------------------------------------
    // RESOLVE: carry-save to sign/magnitude
    // ------------------------------------------------------------------
    logic [AWIDTH-1:0] sum_v;
    logic [AWIDTH-1:0] mag_d;

    always_comb begin
        sum_v = sum_q + carry_q;
        // Negating the most negative value wraps back to 2^(AWIDTH-1), which
        // is exactly the required unsigned magnitude.
        mag_d = sum_v[AWIDTH-1] ? (~sum_v + AWIDTH'(1)) : sum_v;
    end

    // ------------------------------------------------------------------
    // NORM: leading-one detect and left-justify
    // ------------------------------------------------------------------
    logic [PW-1:0]        lead_idx;
    logic [PW-1:0]        shamt;
    logic [AWIDTH-1:0]    norm_d;
    logic signed [XW-1:0] exp_d;

    always_comb begin
        lead_idx = '0;
        for (int unsigned i = 0; i < AWIDTH; i++) begin
            if (mag_q[i]) lead_idx = PW'(i);
        end
        shamt  = PW'(AWIDTH - 1) - lead_idx;
        norm_d = mag_q << shamt;
        exp_d  = XW'({2'b00, lead_idx}) - XW'(FWIDTH);
    end

    // ------------------------------------------------------------------
    // ROUND: field extraction, RNE and special cases
    // ------------------------------------------------------------------
    logic                 is_zero;
    logic [MWIDTH-1:0]    mant_n, mant_s;
    logic                 grd_n, stk_n, grd_s, stk_s;
    logic [MWIDTH:0]      rnd_n, rnd_s;
    logic [XW-1:0]        biased, biased_r;
    logic [DWIDTH-1:0]    ovf_val;

    always_comb begin
        // A zero magnitude stays zero after the shift, so the top bit of the
        // normalised value doubles as the nonzero flag.
        is_zero = ~norm_q[AWIDTH-1];

        mant_n = norm_q[AWIDTH-2 -: MWIDTH];
        grd_n  = norm_q[AWIDTH-2-MWIDTH];
        stk_n  = |norm_q[AWIDTH-3-MWIDTH:0];
        rnd_n  = {1'b0, mant_n} + (MWIDTH+1)'(grd_n & (stk_n | mant_n[0]));

        biased   = XW'(exp_q) + XW'(BIAS);
        biased_r = biased + XW'(rnd_n[MWIDTH]);

        // Subnormal range: magnitude is below 2^(1-BIAS), so every set bit of
        // M lies below SB+MWIDTH and the fixed-position slice is exact.
        mant_s = mag_q[SB +: MWIDTH];
        grd_s  = mag_q[SB-1];
        stk_s  = |mag_q[SB-2:0];
        rnd_s  = {1'b0, mant_s} + (MWIDTH+1)'(grd_s & (stk_s | mant_s[0]));

`ifdef KULISCH_SAT_EN
        ovf_val = {sign_q, {(EWIDTH-1){1'b1}}, 1'b0, {MWIDTH{1'b1}}};
`else
        ovf_val = {sign_q, {EWIDTH{1'b1}}, {MWIDTH{1'b0}}};
`endif

        result_d = '0;
        ovf_d    = 1'b0;
        unf_d    = 1'b0;
        inx_d    = 1'b0;

        if (nan_q) begin
            result_d = {1'b0, {EWIDTH{1'b1}}, 1'b1, {(MWIDTH-1){1'b0}}};
        end else if (is_zero) begin
            result_d = '0;
        end else if (exp_q > EMAX) begin
            result_d = ovf_val;
            ovf_d    = 1'b1;
            inx_d    = 1'b1;
        end else if (exp_q >= EMIN) begin
            inx_d = grd_n | stk_n;
            if (biased_r >= EXP_TOP) begin
                result_d = ovf_val;
                ovf_d    = 1'b1;
            end else begin
                result_d = {sign_q, biased_r[EWIDTH-1:0], rnd_n[MWIDTH-1:0]};
            end
        end else begin
            // A mantissa carry lands in the exponent LSB, giving the smallest
            // normal directly.
            inx_d    = grd_s | stk_s;
            unf_d    = grd_s | stk_s;
            result_d = {sign_q, {(EWIDTH-1){1'b0}}, rnd_s};
        end
    end

    // ------------------------------------------------------------------
    // Datapath registers
    // ------------------------------------------------------------------
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sum_q    <= '0;
            carry_q  <= '0;
            nan_q    <= 1'b0;
            sign_q   <= 1'b0;
            mag_q    <= '0;
            norm_q   <= '0;
            exp_q    <= '0;
            result_q <= '0;
            ovf_q    <= 1'b0;
            unf_q    <= 1'b0;
            inx_q    <= 1'b0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (i_valid) begin
                        sum_q   <= i_sum_acc;
                        carry_q <= i_carry_acc;
                        nan_q   <= i_nan;
                    end
                end
                RESOLVE: begin
                    sign_q <= sum_v[AWIDTH-1];
                    mag_q  <= mag_d;
                end
                NORM: begin
                    norm_q <= norm_d;
                    exp_q  <= exp_d;
                end
                ROUND: begin
                    result_q <= result_d;
                    ovf_q    <= ovf_d;
                    unf_q    <= unf_d;
                    inx_q    <= inx_d;
                end
                default: ;
            endcase
        end
    end

    assign o_result    = result_q;
    assign o_overflow  = ovf_q;
    assign o_underflow = unf_q;
    assign o_inexact   = inx_q;

endmodule

// File: tb/tb_kulisch_to_fp16.sv
// tb_kulisch_to_fp16
//   Directed-vector bench for kulisch_to_fp16 with hand-computed FP16 results
//   and flag triples {overflow, underflow, inexact}. Covers reset values,
//   latency, RNE ties, overflow, subnormals, NaN, backpressure and mid-flight
//   reset. Expected overflow values follow KULISCH_SAT_EN when defined.

module tb_kulisch_to_fp16;

    localparam int AW = 92;

    logic          clk = 1'b0;
    logic          rst_n;
    logic          i_valid;
    logic          o_ready;
    logic [AW-1:0] i_sum_acc;
    logic [AW-1:0] i_carry_acc;
    logic          i_nan;
    logic          o_valid;
    logic          i_ready;
    logic [15:0]   o_result;
    logic          o_overflow;
    logic          o_underflow;
    logic          o_inexact;

    int n_cmp = 0;
    int n_err = 0;

`ifdef KULISCH_SAT_EN
    localparam logic [15:0] OVF_POS = 16'h7BFF;
    localparam logic [15:0] OVF_NEG = 16'hFBFF;
`else
    localparam logic [15:0] OVF_POS = 16'h7C00;
    localparam logic [15:0] OVF_NEG = 16'hFC00;
`endif

    kulisch_to_fp16 #(
        .AWIDTH(92),
        .FWIDTH(48),
        .DWIDTH(16),
        .EWIDTH(5),
        .MWIDTH(10)
    ) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .i_valid    (i_valid),
        .o_ready    (o_ready),
        .i_sum_acc  (i_sum_acc),
        .i_carry_acc(i_carry_acc),
        .i_nan      (i_nan),
        .o_valid    (o_valid),
        .i_ready    (i_ready),
        .o_result   (o_result),
        .o_overflow (o_overflow),
        .o_underflow(o_underflow),
        .o_inexact  (o_inexact)
    );

    always #5 clk = ~clk;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    function automatic logic [AW-1:0] neg(input logic [AW-1:0] x);
        return ~x + AW'(1);
    endfunction

    function automatic logic [AW-1:0] sh(input logic [AW-1:0] x, input int n);
        return x << n;
    endfunction

    // Launch one operand and wait for the result; optionally release it.
    task automatic run_txn(input string tag, input logic [AW-1:0] s, input logic [AW-1:0] c,
                           input logic n, input logic [15:0] er, input logic [2:0] ef,
                           input bit release_it);
        int cyc;
        @(negedge clk);
        check_eq({tag, ".ready"}, 32'(o_ready), 32'd1);
        i_sum_acc   = s;
        i_carry_acc = c;
        i_nan       = n;
        i_valid     = 1'b1;
        @(posedge clk);
        #1;
        i_valid = 1'b0;
        cyc = 0;
        while (!o_valid && cyc < 10) begin
            @(posedge clk);
            #1;
            cyc++;
        end
        check_eq({tag, ".lat"}, 32'(cyc), 32'd3);
        check_eq({tag, ".res"}, 32'(o_result), 32'(er));
        check_eq({tag, ".flg"}, 32'({o_overflow, o_underflow, o_inexact}), 32'(ef));
        if (release_it) begin
            @(negedge clk);
            i_ready = 1'b1;
            @(posedge clk);
            #1;
            i_ready = 1'b0;
            check_eq({tag, ".vdrop"}, 32'(o_valid), 32'd0);
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int seen;
        rst_n       = 1'b0;
        i_valid     = 1'b0;
        i_ready     = 1'b0;
        i_nan       = 1'b0;
        i_sum_acc   = '0;
        i_carry_acc = '0;
        #23;
        check_eq("rst.ready", 32'(o_ready), 32'd1);
        check_eq("rst.valid", 32'(o_valid), 32'd0);
        check_eq("rst.res",   32'(o_result), 32'h0);
        check_eq("rst.flg",   32'({o_overflow, o_underflow, o_inexact}), 32'd0);
        @(negedge clk);
        rst_n = 1'b1;

        run_txn("one",     sh(1, 48), '0, 1'b0, 16'h3C00, 3'b000, 1);
        run_txn("p75",     sh(1, 48), neg(sh(1, 46)), 1'b0, 16'h3A00, 3'b000, 1);
        run_txn("m15",     neg(sh(3, 47)), '0, 1'b0, 16'hBE00, 3'b000, 1);
        run_txn("tie_dn",  sh(1, 48) | sh(1, 37), '0, 1'b0, 16'h3C00, 3'b001, 1);
        run_txn("tie_up",  sh(1, 48) | sh(3, 37), '0, 1'b0, 16'h3C02, 3'b001, 1);
        run_txn("rnd_ovf", sh(65520, 48), '0, 1'b0, OVF_POS, 3'b101, 1);
        run_txn("maxnorm", sh(65504, 48), '0, 1'b0, 16'h7BFF, 3'b000, 1);
        run_txn("e_ovf",   sh(1, 64), '0, 1'b0, OVF_POS, 3'b101, 1);
        run_txn("minneg",  sh(1, 91), '0, 1'b0, OVF_NEG, 3'b101, 1);
        run_txn("sub1",    sh(1, 24), '0, 1'b0, 16'h0001, 3'b000, 1);
        run_txn("sub_tz",  sh(1, 23), '0, 1'b0, 16'h0000, 3'b011, 1);
        run_txn("sub_ntz", neg(sh(1, 23)), '0, 1'b0, 16'h8000, 3'b011, 1);
        run_txn("sub_car", sh(1023, 24) | sh(1, 23) | AW'(1), '0, 1'b0, 16'h0400, 3'b011, 1);
        run_txn("minnorm", sh(1, 34), '0, 1'b0, 16'h0400, 3'b000, 1);
        run_txn("zero",    AW'(5), neg(AW'(5)), 1'b0, 16'h0000, 3'b000, 1);
        run_txn("nan",     sh(1, 48), '0, 1'b1, 16'h7E00, 3'b000, 1);

        // Backpressure: result must sit untouched while i_ready is low.
        run_txn("hold", sh(3, 47), '0, 1'b0, 16'h3E00, 3'b000, 0);
        for (int k = 0; k < 5; k++) begin
            @(posedge clk);
            #1;
            check_eq("hold.valid", 32'(o_valid), 32'd1);
            check_eq("hold.res",   32'(o_result), 32'h3E00);
            check_eq("hold.ready", 32'(o_ready), 32'd0);
        end
        @(negedge clk);
        i_ready = 1'b1;
        @(posedge clk);
        #1;
        i_ready = 1'b0;
        check_eq("hold.rel", 32'(o_valid), 32'd0);

        // Reset while the operand is in NORM.
        @(negedge clk);
        i_sum_acc   = sh(1, 48);
        i_carry_acc = '0;
        i_nan       = 1'b0;
        i_valid     = 1'b1;
        @(posedge clk);
        #1;
        i_valid = 1'b0;
        @(posedge clk);
        #2;
        rst_n = 1'b0;
        #1;
        check_eq("mrst.valid", 32'(o_valid), 32'd0);
        check_eq("mrst.ready", 32'(o_ready), 32'd1);
        check_eq("mrst.res",   32'(o_result), 32'h0);
        @(negedge clk);
        rst_n = 1'b1;
        seen = 0;
        for (int k = 0; k < 8; k++) begin
            @(posedge clk);
            #1;
            if (o_valid) seen++;
        end
        check_eq("mrst.stale", 32'(seen), 32'd0);
        check_eq("mrst.ready2", 32'(o_ready), 32'd1);

        run_txn("post", neg(sh(1, 48)), '0, 1'b0, 16'hBC00, 3'b000, 1);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
